// File: rtl/blk_arbiter.sv
// Round-robin block arbiter: merges framed blocks from NCH channels into one 16-bit stream.
// Optional block timeout compiled in with `define BLK_ARBITER_TIMEOUT_EN.
module blk_arbiter #(
  parameter int NCH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [16*NCH-1:0] din,
  output logic [NCH-1:0]    ack,
  input  logic              full,
  output logic [15:0]       dout,
  output logic              dvalid,
  output logic              dlast,
  output logic              err
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [PW-1:0]  grant_q, grant_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [8:0]     rem_q, rem_d;
  logic [NCH-1:0] ack_q, ack_d;
  logic [15:0]    dout_q, dout_d;
  logic           dvalid_q, dvalid_d;
  logic           dlast_q, dlast_d;
  logic           err_q, err_d;
`ifdef BLK_ARBITER_TIMEOUT_EN
  logic [7:0]     to_cnt_q, to_cnt_d;
`endif

  logic [15:0]    word_s;
  logic           req_g_s;
  logic [NCH-1:0] grant_oh_s;
  logic           rr_found_s;
  logic [PW-1:0]  rr_idx_s;
  logic [PW:0]    rr_c_s;

  assign word_s     = din[{grant_q, 4'b0000} +: 16];
  assign req_g_s    = req[grant_q];
  assign grant_oh_s = NCH'(1) << grant_q;

  // First requesting channel at or after the priority pointer, wrapping at NCH.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    rr_c_s     = '0;
    for (int i = 0; i < NCH; i++) begin
      rr_c_s = {1'b0, ptr_q} + (PW+1)'(i);
      if (rr_c_s >= (PW+1)'(NCH)) begin
        rr_c_s = rr_c_s - (PW+1)'(NCH);
      end else begin
        rr_c_s = rr_c_s;
      end
      if (!rr_found_s && req[rr_c_s[PW-1:0]]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = rr_c_s[PW-1:0];
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Next-state logic: a non-zero ack_q marks the one-cycle gap before the next sample.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    ack_d    = '0;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    dlast_d  = 1'b0;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_found_s && (ack_q == '0)) begin
          grant_d = rr_idx_s;
          ptr_d   = (rr_idx_s == PW'(NCH-1)) ? '0 : rr_idx_s + PW'(1);
          state_d = ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (!req_g_s) begin
          state_d = ST_IDLE;
        end else if (!full) begin
          ack_d = grant_oh_s;
          if (!word_s[15]) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // remaining = total - 1: L for a trigger header, L+1 for a master header
            rem_d    = {1'b0, word_s[7:0]} + {8'd0, word_s[14]};
            dout_d   = word_s;
            dvalid_d = 1'b1;
            if ((word_s[7:0] == 8'd0) && !word_s[14]) begin
              dlast_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_GAP;
            end
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_GAP: begin
        state_d = ST_BODY;
      end
      ST_BODY: begin
        if (req_g_s && !full) begin
          ack_d    = grant_oh_s;
          dout_d   = word_s;
          dvalid_d = 1'b1;
          rem_d    = rem_q - 9'd1;
          if (rem_q == 9'd1) begin
            dlast_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end else begin
          state_d = ST_BODY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifdef BLK_ARBITER_TIMEOUT_EN
    to_cnt_d = 8'd0;
    if (((state_q == ST_GAP) || (state_q == ST_BODY)) && !req_g_s) begin
      if (to_cnt_q == 8'hFF) begin
        ack_d    = '0;
        dout_d   = 16'h0000;
        dvalid_d = 1'b1;
        dlast_d  = 1'b1;
        err_d    = 1'b1;
        state_d  = ST_IDLE;
      end else begin
        to_cnt_d = to_cnt_q + 8'd1;
      end
    end else begin
      to_cnt_d = 8'd0;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      rem_q    <= 9'd0;
      ack_q    <= '0;
      dout_q   <= 16'h0000;
      dvalid_q <= 1'b0;
      dlast_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef BLK_ARBITER_TIMEOUT_EN
      to_cnt_q <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      ack_q    <= ack_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      dlast_q  <= dlast_d;
      err_q    <= err_d;
`ifdef BLK_ARBITER_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign ack    = ack_q;
  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign dlast  = dlast_q;
  assign err    = err_q;

endmodule

// File: tb/tb_blk_arbiter.sv
// Directed, table-driven bench for blk_arbiter; per-channel word queues model the producers.
module tb_blk_arbiter;
  localparam int NCH = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    req;
  logic [16*NCH-1:0] din;
  logic [NCH-1:0]    ack;
  logic              full;
  logic [15:0]       dout;
  logic              dvalid;
  logic              dlast;
  logic              err;

  blk_arbiter #(.NCH(NCH)) dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .ack(ack), .full(full),
    .dout(dout), .dvalid(dvalid), .dlast(dlast), .err(err)
  );

  always #4 clk = ~clk;

  typedef struct {
    int          ch;
    logic [15:0] w0, w1, w2;
    int          nw;
    int          exp_out;
    int          exp_acks;
    logic        exp_err;
  } vec_t;

  logic [15:0]    q [NCH][$];
  logic [NCH-1:0] mask_v;
  logic           full_v;
  int             n_cmp = 0;
  int             n_bad = 0;
  int             cyc = 0;
  logic [15:0]    out_w[$];
  logic           out_l[$];
  int             ack_ch[$];
  int             ack_cyc[$];
  vec_t           vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      req[c] = (q[c].size() > 0) && !mask_v[c];
      din[c*16 +: 16] = (q[c].size() > 0) ? q[c][0] : 16'h0000;
    end
    full = full_v;
  endtask

  task automatic clear_logs();
    out_w.delete(); out_l.delete(); ack_ch.delete(); ack_cyc.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    n_cmp++;
    if (($countones(ack) > 1) || (dlast && !dvalid)) begin
      n_bad++;
      $display("FAIL ack_onehot_dlast: ack=%b dlast=%b dvalid=%b", ack, dlast, dvalid);
    end
    if (dvalid) begin
      out_w.push_back(dout);
      out_l.push_back(dlast);
    end
    for (int c = 0; c < NCH; c++) begin
      if (ack[c]) begin
        ack_ch.push_back(c);
        ack_cyc.push_back(cyc);
        if (q[c].size() > 0) void'(q[c].pop_front());
      end
    end
    drive();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    full_v = 1'b0;
    mask_v = '0;
    for (int c = 0; c < NCH; c++) q[c].delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic check_stream(input string tag, input logic [15:0] e[$]);
    chk({tag, "_count"}, out_w.size(), e.size());
    for (int i = 0; i < e.size(); i++) begin
      if (i < out_w.size()) begin
        chk($sformatf("%s_word%0d", tag, i), out_w[i], e[i]);
        chk($sformatf("%s_last%0d", tag, i), out_l[i], (i == e.size() - 1) ? 1 : 0);
      end
    end
  endtask

  initial begin
    logic [15:0] wv[3];
    logic [15:0] e[$];
    int          n0, a0;

    vt[0] = '{3, 16'h8302, 16'hD000, 16'hD001, 3, 3, 3, 1'b0};
    vt[1] = '{5, 16'hC501, 16'h8ABC, 16'h1234, 3, 3, 3, 1'b0};
    vt[2] = '{0, 16'h8000, 16'h0000, 16'h0000, 1, 1, 1, 1'b0};
    vt[3] = '{6, 16'hC000, 16'h5555, 16'h0000, 2, 2, 2, 1'b0};
    vt[4] = '{2, 16'h0123, 16'h0000, 16'h0000, 1, 0, 1, 1'b1};
    vt[5] = '{7, 16'h8001, 16'h0102, 16'h0000, 2, 2, 2, 1'b0};

    do_reset();
    chk("rst_ack", ack, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dvalid", dvalid, 0);
    chk("rst_dlast", dlast, 0);
    chk("rst_err", err, 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      wv[0] = vt[v].w0; wv[1] = vt[v].w1; wv[2] = vt[v].w2;
      e.delete();
      for (int i = 0; i < vt[v].nw; i++) q[vt[v].ch].push_back(wv[i]);
      for (int i = 0; i < vt[v].exp_out; i++) e.push_back(wv[i]);
      drive();
      repeat (30) tick();
      check_stream($sformatf("v%0d", v), e);
      chk($sformatf("v%0d_acks", v), ack_ch.size(), vt[v].exp_acks);
      for (int i = 0; i < ack_ch.size(); i++)
        chk($sformatf("v%0d_ackch%0d", v, i), ack_ch[i], vt[v].ch);
      for (int i = 1; i < ack_cyc.size(); i++)
        chk($sformatf("v%0d_ackgap%0d", v, i), (ack_cyc[i] - ack_cyc[i-1]) >= 2, 1);
      chk($sformatf("v%0d_err", v), err, vt[v].exp_err);
      chk($sformatf("v%0d_left", v), q[vt[v].ch].size(), vt[v].nw - vt[v].exp_acks);
    end

    // Desync leaves the arbiter idle and able to serve the next block; err stays set.
    do_reset();
    q[2].push_back(16'h0123);
    drive();
    repeat (20) tick();
    chk("desync_nodv", out_w.size(), 0);
    q[4].push_back(16'h8000);
    drive();
    repeat (20) tick();
    e = '{16'h8000};
    check_stream("desync_after", e);
    chk("desync_err", err, 1);

    // Round robin after a grant to channel 1: expect 7, 0, 1.
    do_reset();
    q[1].push_back(16'h8000);
    drive();
    repeat (20) tick();
    clear_logs();
    q[0].push_back(16'h8000); q[1].push_back(16'h8000); q[7].push_back(16'h8000);
    drive();
    repeat (40) tick();
    chk("rr_count", ack_ch.size(), 3);
    if (ack_ch.size() == 3) begin
      chk("rr_first", ack_ch[0], 7);
      chk("rr_second", ack_ch[1], 0);
      chk("rr_third", ack_ch[2], 1);
    end

    // Backpressure for 10 cycles mid-block, then the granted req drops for 6 cycles.
    do_reset();
    e = '{16'h8304, 16'hA000, 16'hA001, 16'hA002, 16'hA003};
    foreach (e[i]) q[3].push_back(e[i]);
    drive();
    for (int k = 0; k < 50 && out_w.size() < 2; k++) tick();
    chk("stall_setup", out_w.size(), 2);
    full_v = 1'b1;
    drive();
    n0 = out_w.size(); a0 = ack_ch.size();
    repeat (10) tick();
    chk("full_nodv", out_w.size() - n0, 0);
    chk("full_noack", ack_ch.size() - a0, 0);
    full_v = 1'b0;
    mask_v[3] = 1'b1;
    drive();
    repeat (6) tick();
    chk("reqlow_nodv", out_w.size() - n0, 0);
    chk("reqlow_noack", ack_ch.size() - a0, 0);
    mask_v[3] = 1'b0;
    drive();
    repeat (40) tick();
    check_stream("stall", e);
    chk("stall_acks", ack_ch.size(), 5);
    chk("stall_err", err, 0);

    // Asynchronous reset mid-block abandons the block; the next one starts clean.
    do_reset();
    q[3].push_back(16'h8302); q[3].push_back(16'hD000); q[3].push_back(16'hD001);
    drive();
    for (int k = 0; k < 20 && out_w.size() < 1; k++) tick();
    chk("arst_setup", dvalid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_dvalid", dvalid, 0);
    chk("arst_dout", dout, 0);
    chk("arst_ack", ack, 0);
    do_reset();
    q[1].push_back(16'h8000);
    drive();
    repeat (20) tick();
    e = '{16'h8000};
    check_stream("post_rst", e);

`ifdef BLK_ARBITER_TIMEOUT_EN
    do_reset();
    q[4].push_back(16'h8303); q[4].push_back(16'h0001);
    q[4].push_back(16'h0002); q[4].push_back(16'h0003);
    drive();
    for (int k = 0; k < 20 && out_w.size() < 1; k++) tick();
    mask_v[4] = 1'b1;
    drive();
    repeat (250) tick();
    chk("to_early", out_w.size(), 1);
    repeat (50) tick();
    e = '{16'h8303, 16'h0000};
    check_stream("timeout", e);
    chk("to_err", err, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
